// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: drives mic_clk, samples the 1-bit stream and
// decimates it with a 3rd-order CIC into held signed 12-bit PCM samples.
module pdm_mic_decimator #(
  parameter int CLK_DIV  = 8,
  parameter int DEC_LOG2 = 6
) (
  input  logic        wb_clk_i,
  input  logic        wb_reset_i,
  input  logic        enable,
  output logic        mic_clk,
  input  logic        mic_data,
  output logic [11:0] audio,
  output logic        audio_valid
);

  localparam int ACC_W = 3*DEC_LOG2 + 2;
  localparam int SHIFT = 3*DEC_LOG2 - 11;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-2048);

  logic                    w_clr;
  logic                    w_div_wrap;
  logic                    w_sample_en;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_c1;
  logic signed [ACC_W-1:0] w_c2;
  logic signed [ACC_W-1:0] w_c3;
  logic signed [ACC_W-1:0] w_shifted;
  logic [11:0]             w_sat;

  logic [DIV_W-1:0]        r_div;
  logic                    r_mic_clk;
  logic                    r_sync1;
  logic                    r_sync2;
  logic [DEC_LOG2-1:0]     r_dec;
  logic                    r_dec_stb;
  logic signed [ACC_W-1:0] r_i1;
  logic signed [ACC_W-1:0] r_i2;
  logic signed [ACC_W-1:0] r_i3;
  logic signed [ACC_W-1:0] r_d1;
  logic signed [ACC_W-1:0] r_d2;
  logic signed [ACC_W-1:0] r_d3;
  logic signed [ACC_W-1:0] r_c3;
  logic                    r_comb_vld;
  logic [1:0]              r_settle;
  logic [11:0]             r_audio;
  logic                    r_audio_valid;

  assign w_clr       = wb_reset_i | ~enable;
  assign w_div_wrap  = (r_div == DIV_W'(CLK_DIV - 1));
  // The mic drives data on the rising edge; take it at the end of the high phase.
  assign w_sample_en = w_div_wrap & r_mic_clk;
  assign w_x         = r_sync2 ? ACC_W'(1) : {ACC_W{1'b1}};

  assign w_c1 = r_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  assign w_shifted = r_c3 >>> SHIFT;

  always_comb begin
    w_sat = w_shifted[11:0];
    if (w_shifted > SAT_MAX) begin
      w_sat = 12'h7FF;
    end else if (w_shifted < SAT_MIN) begin
      w_sat = 12'h800;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_clr) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
    end else begin
      r_sync1 <= mic_data;
      r_sync2 <= r_sync1;
      if (w_div_wrap) begin
        r_div     <= '0;
        r_mic_clk <= ~r_mic_clk;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_clr) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i3      <= '0;
      r_dec     <= '0;
      r_dec_stb <= 1'b0;
    end else begin
      r_dec_stb <= 1'b0;
      if (w_sample_en) begin
        r_i1  <= r_i1 + w_x;
        r_i2  <= r_i2 + r_i1;
        r_i3  <= r_i3 + r_i2;
        r_dec <= r_dec + 1'b1;
        if (r_dec == {DEC_LOG2{1'b1}}) begin
          r_dec_stb <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_clr) begin
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_c3       <= '0;
      r_comb_vld <= 1'b0;
    end else begin
      r_comb_vld <= r_dec_stb;
      if (r_dec_stb) begin
        r_d1 <= r_i3;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        r_c3 <= w_c3;
      end
    end
  end

  // The first three comb results still carry the CIC start-up transient.
  always_ff @(posedge wb_clk_i) begin
    if (w_clr) begin
      r_settle      <= '0;
      r_audio       <= '0;
      r_audio_valid <= 1'b0;
    end else begin
      r_audio_valid <= 1'b0;
      if (r_comb_vld) begin
        if (r_settle != 2'd3) begin
          r_settle <= r_settle + 2'd1;
        end else begin
          r_audio       <= w_sat;
          r_audio_valid <= 1'b1;
        end
      end
    end
  end

  assign mic_clk     = r_mic_clk;
  assign audio       = r_audio;
  assign audio_valid = r_audio_valid;

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Directed bench for pdm_mic_decimator: timing of mic_clk and audio_valid,
// and steady-state PCM values for held and periodic PDM patterns.
module tb_pdm_mic_decimator;

  logic        wb_clk_i;
  logic        wb_reset_i;
  logic        enable;
  logic        mic_clk;
  logic        mic_data;
  logic [11:0] audio;
  logic        audio_valid;

  int tests_run;
  int tests_failed;

  bit pat [4];
  int plen;
  int pidx;

  pdm_mic_decimator #(.CLK_DIV(8), .DEC_LOG2(6)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_reset_i  (wb_reset_i),
    .enable      (enable),
    .mic_clk     (mic_clk),
    .mic_data    (mic_data),
    .audio       (audio),
    .audio_valid (audio_valid)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // New PDM bit is presented on each mic_clk rising edge, as a real mic does.
  initial begin
    forever begin
      @(posedge mic_clk);
      mic_data = pat[pidx];
      pidx = (pidx + 1 >= plen) ? 0 : pidx + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
    $display("[TB] %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic set_pattern(input bit b0, input bit b1, input bit b2, input bit b3,
                             input int len);
    pat[0] = b0; pat[1] = b1; pat[2] = b2; pat[3] = b3;
    plen = len;
    pidx = 0;
    mic_data = b0;
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wait_rise(input int budget, output int cycles);
    logic prev;
    prev = mic_clk;
    cycles = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (mic_clk && !prev) return;
      prev = mic_clk;
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (audio_valid) return;
    end
  endtask

  // Called right after a clock edge with the block held in reset.
  task automatic restart(input string tag, input int exp_audio);
    int c;
    int t;
    wb_reset_i = 1'b0;
    enable     = 1'b1;
    wait_rise(100, c);
    chk({tag, "_first_rise"}, c, 8);
    t = c;
    wait_rise(100, c);
    chk({tag, "_mic_clk_period"}, c, 16);
    t += c;
    wait_valid(6000, c);
    t += c;
    chk({tag, "_first_valid_cycle"}, t, 4098);
    chk({tag, "_first_audio"}, int'($signed(audio)), exp_audio);
    tick();
    chk({tag, "_valid_one_cycle"}, int'(audio_valid), 0);
    chk({tag, "_audio_held"}, int'($signed(audio)), exp_audio);
  endtask

  task automatic next_sample(input string tag, input int exp_audio);
    int c;
    wait_valid(2000, c);
    chk({tag, "_spacing"}, c, 1023);
    chk({tag, "_audio"}, int'($signed(audio)), exp_audio);
    tick();
  endtask

  task automatic hold_reset();
    wb_reset_i = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int c;
    tests_run    = 0;
    tests_failed = 0;
    wb_reset_i   = 1'b1;
    enable       = 1'b1;
    set_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1);

    // Reset state, then held-1 full-scale output
    repeat (5) tick();
    chk("rst_mic_clk", int'(mic_clk), 0);
    chk("rst_audio", int'(audio), 0);
    chk("rst_valid", int'(audio_valid), 0);
    restart("held1", 2047);
    next_sample("held1_s2", 2047);
    next_sample("held1_s3", 2047);

    // Held 0: negative full scale
    hold_reset();
    set_pattern(1'b0, 1'b0, 1'b0, 1'b0, 1);
    restart("held0", -2048);
    next_sample("held0_s2", -2048);

    // Alternating 1,0: zero mean
    hold_reset();
    set_pattern(1'b1, 1'b0, 1'b0, 1'b0, 2);
    restart("alt", 0);
    next_sample("alt_s2", 0);

    // 75% density, then switch to 25% density
    hold_reset();
    set_pattern(1'b1, 1'b1, 1'b1, 1'b0, 4);
    restart("d75", 1024);
    next_sample("d75_s2", 1024);
    set_pattern(1'b1, 1'b0, 1'b0, 1'b0, 4);
    wait_valid(2000, c);
    tick();
    wait_valid(2000, c);
    tick();
    next_sample("d25_s3", -1024);
    next_sample("d25_s4", -1024);

    // Reset pulse mid-frame on a held-1 stream
    hold_reset();
    set_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1);
    restart("pre_pulse", 2047);
    repeat (500) tick();
    wb_reset_i = 1'b1;
    tick();
    chk("pulse_audio", int'(audio), 0);
    chk("pulse_valid", int'(audio_valid), 0);
    chk("pulse_mic_clk", int'(mic_clk), 0);
    restart("after_pulse", 2047);

    // Enable dropped for 100 cycles
    repeat (300) tick();
    enable = 1'b0;
    tick();
    chk("dis_audio", int'(audio), 0);
    chk("dis_mic_clk", int'(mic_clk), 0);
    repeat (99) tick();
    restart("after_enable", 2047);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pdm_mic_decimator.md
Name: pdm_mic_decimator

Overview:
- Upstream audio front end for wb_misc.
- Drives the clock of a PDM MEMS microphone and samples its 1-bit data stream.
- Converts the stream to signed 12-bit PCM with a 3rd-order CIC decimator.
- Presents a held sample on `audio`, which is wired straight into wb_misc's audio input, plus a one-cycle strobe for future FIFO/interrupt use.

Parameters:
- CLK_DIV, 8: wb_clk_i cycles per mic_clk half-period. mic_clk period = 2*CLK_DIV cycles. Must be >= 2.
- DEC_LOG2, 6: log2 of the decimation ratio R. R = 2^DEC_LOG2 PDM bits per output sample. Must be 4..8.

Ports:
- wb_clk_i, input, 1: system clock; the only clock.
- wb_reset_i, input, 1: synchronous, active-high reset.
- enable, input, 1: run the microphone and filter. Low has the same effect as reset.
- mic_clk, output, 1: PDM clock to the microphone; registered.
- mic_data, input, 1: PDM data from the microphone; asynchronous.
- audio, output, 12: signed PCM sample, two's complement, held between updates.
- audio_valid, output, 1: one-cycle pulse on the cycle `audio` changes to a new sample.

Behaviour:
- Reset (wb_reset_i=1 or enable=0, sampled at posedge):
  - mic_clk=0, audio=0, audio_valid=0.
  - Divider, decimation counter, settle counter, integrators, comb delays and synchronizer all cleared.
  - Applies at any point mid-operation, including the cycle a sample would be emitted; that sample is discarded.
- Clock divider:
  - Counter 0..CLK_DIV-1; mic_clk toggles when the counter wraps.
  - First rising edge of mic_clk occurs CLK_DIV cycles after reset deasserts.
- Input capture:
  - mic_data passes through a 2-flop synchronizer.
  - sample_en is asserted for one cycle on the cycle mic_clk is driven 1->0, i.e. at the end of the high phase.
  - On sample_en, the synchronizer output is taken as the PDM bit: 1 maps to +1, 0 maps to -1.
- Widths: ACC_W = 3*DEC_LOG2+2 (20 bits at default). All filter arithmetic is signed ACC_W, two's-complement wrap.
- Integrators:
  - Three cascaded integrators I1 += x, I2 += I1, I3 += I2.
  - Update only on sample_en, using the register values from before that update.
- Decimation:
  - Counter 0..R-1, incremented on sample_en.
  - On the sample_en where it wraps R-1 -> 0, a decimate strobe fires the next cycle using the updated I3.
- Combs (on the decimate strobe, one cycle, registered):
  - C1 = I3 - D1
  - C2 = C1 - D2
  - C3 = C2 - D3
  - D1..D3 take the new comb inputs.
- Output scaling:
  - y = C3 arithmetic-shifted right by 3*DEC_LOG2-11 (7 at default).
  - Saturate to [-2048, 2047].
  - Full scale +/-R^3 therefore maps to +2047 (clamped) / -2048.
- Settling:
  - The first 3 decimate results after reset are discarded (CIC transient).
  - audio stays 0 and audio_valid does not pulse for them.
- Output:
  - audio is registered and audio_valid pulses on the cycle after the comb computation.
  - Latency is 2 cycles after the R-th sample_en.
  - Steady-state pulse period is R*2*CLK_DIV cycles (1024 at default).
- Simultaneous events: the decimate strobe and sample_en never coincide because CLK_DIV >= 2.
- Behaviour is undefined for out-of-range parameters.

Test Plan:
1. Reset, then enable=1: mic_clk=0, audio=0, audio_valid=0 during reset. mic_clk first rises 8 cycles after release, then has period 16. No audio_valid within the first 3*1024 cycles.
2. mic_data held 1: the 4th decimate yields audio=2047 (0x7FF) with a single-cycle audio_valid. Later pulses come exactly 1024 cycles apart, all 2047.
3. mic_data held 0: first valid sample is -2048 (0x800), and every following sample is -2048.
4. mic_data pattern 1,0,1,0 (aligned to sample_en): first valid sample is 0, as are all following samples.
5. Pattern 1,1,1,0 (75% density): steady samples are exactly 1024. Switching to 1,0,0,0 settles within 3 samples to -1024.
6. Held-1 stream, then wb_reset_i pulsed for one cycle mid-frame, and separately enable dropped for 100 cycles: audio returns to 0 next cycle. Restart timing matches test 1, and 2047 reappears on the 4th decimate after restart.
